// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter
//
// Shares data port B of the dual-port program/data RAM between two masters:
// master 0 (core data interface) and master 1 (loader / debug). One
// single-cycle RAM access is issued per clock. A master may lock the port
// for read-modify-write sequences, and a watchdog breaks locks that are held
// for LOCK_MAX consecutive cycles.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> idle ties go to the master that was not
//                                    granted most recently.
//                       undefined -> fixed priority, master 0 wins ties.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   mN_req_i/we_i/lock_i          request, write enable, hold-ownership flag
//   mN_addr_i/wdata_i             access address and write data
//   mN_gnt_o                      access accepted this cycle (combinational)
//   mN_rvalid_o/rdata_o           read return, one cycle after the grant
//   lock_err_o                    one-cycle pulse when the watchdog fires
//   mem_we_o/addr_o/data_o        to RAM we_b/addr_b/data_b
//   mem_data_i                    from RAM q_b (registered inside the RAM)
module dpram_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic                  m0_lock_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WIDTH-1:0]      m0_wdata_i,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic                  m1_lock_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WIDTH-1:0]      m1_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m1_gnt_o,
    output logic                  m0_rvalid_o,
    output logic                  m1_rvalid_o,
    output logic [WIDTH-1:0]      m0_rdata_o,
    output logic [WIDTH-1:0]      m1_rdata_o,
    output logic                  lock_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_data_o,
    input  logic [WIDTH-1:0]      mem_data_i
);

    localparam int              CNT_W    = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;       // completed cycles in the current lock
    logic             r_rvalid0;
    logic             r_rvalid1;
    logic             r_lock_err;
`ifdef ARB_ROUND_ROBIN_EN
    logic             r_last;      // 1 = master 1 was granted most recently
`endif

    logic w_gnt0;
    logic w_gnt1;

    // Grant decision: purely combinational so an accepted access reaches
    // the RAM in the same cycle it is requested.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_i) begin
            case (r_state)
                IDLE: begin
                    if (m0_req_i && m1_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
`else
                        w_gnt0 = 1'b1;
`endif
                    end else begin
                        w_gnt0 = m0_req_i;
                        w_gnt1 = m1_req_i;
                    end
                end
                LOCK0:   w_gnt0 = m0_req_i;
                LOCK1:   w_gnt1 = m1_req_i;
                default: ;
            endcase
        end
    end

    // RAM port mux; an idle port drives zeros so nothing spurious is written.
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        if (w_gnt0) begin
            mem_we_o   = m0_we_i;
            mem_addr_o = m0_addr_i;
            mem_data_o = m0_wdata_i;
        end else if (w_gnt1) begin
            mem_we_o   = m1_we_i;
            mem_addr_o = m1_addr_i;
            mem_data_o = m1_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_lock_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last     <= 1'b1;
`endif
        end else begin
            r_rvalid0  <= w_gnt0 & ~m0_we_i;
            r_rvalid1  <= w_gnt1 & ~m1_we_i;
            r_lock_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
`endif
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_gnt0 && m0_lock_i) begin
                        r_state <= LOCK0;
                    end else if (w_gnt1 && m1_lock_i) begin
                        r_state <= LOCK1;
                    end
                end
                LOCK0: begin
                    // Watchdog wins over everything; the access granted in
                    // this final locked cycle still completes normally.
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_lock_err <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last     <= 1'b0;
`endif
                    end else if (!m0_req_i || !m0_lock_i) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LOCK1: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_lock_err <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last     <= 1'b1;
`endif
                    end else if (!m1_req_i || !m1_lock_i) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Registered flags are masked while reset is held so a read returning in
    // the reset cycle is dropped and every output shows its reset value.
    assign m0_gnt_o    = w_gnt0;
    assign m1_gnt_o    = w_gnt1;
    assign m0_rvalid_o = r_rvalid0 & ~rst_i;
    assign m1_rvalid_o = r_rvalid1 & ~rst_i;
    assign m0_rdata_o  = m0_rvalid_o ? mem_data_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_data_i : '0;
    assign lock_err_o  = r_lock_err & ~rst_i;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;

    localparam int LOCK_MAX = 16;

    logic        clk;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic        lk    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lock_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] ram_q;

    logic [31:0] ram    [256];
    logic [31:0] shadow [256];

    int n_checks;
    int n_fail;
    int cyc;

    dpram_port_arbiter #(
        .WIDTH     (32),
        .ADDR_WIDTH(32),
        .LOCK_MAX  (LOCK_MAX)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0_req_i   (req[0]),
        .m0_we_i    (we[0]),
        .m0_lock_i  (lk[0]),
        .m0_addr_i  (addr[0]),
        .m0_wdata_i (wd[0]),
        .m1_req_i   (req[1]),
        .m1_we_i    (we[1]),
        .m1_lock_i  (lk[1]),
        .m1_addr_i  (addr[1]),
        .m1_wdata_i (wd[1]),
        .m0_gnt_o   (m0_gnt),
        .m1_gnt_o   (m1_gnt),
        .m0_rvalid_o(m0_rvalid),
        .m1_rvalid_o(m1_rvalid),
        .m0_rdata_o (m0_rdata),
        .m1_rdata_o (m1_rdata),
        .lock_err_o (lock_err),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_wdata),
        .mem_data_i (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B RAM: registered read, one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
        ram_q <= ram[mem_addr[9:2]];
    end

    // ---------------- reference model ----------------
    int          m_owner;   // -1 none, else owning master
    int          m_held;    // locked cycles completed
    bit          m_rv [2];
    logic [31:0] m_rd;
    bit          m_err;
`ifdef ARB_ROUND_ROBIN_EN
    int          m_last;
`endif

    function automatic int model_grant();
        if (rst) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_rv[0] = 0;
            m_rv[1] = 0;
            m_err   = 0;
`ifdef ARB_ROUND_ROBIN_EN
            m_last  = 1;
`endif
        end else begin
            m_rv[0] = (g == 0) && !we[0];
            m_rv[1] = (g == 1) && !we[1];
            m_err   = 0;
            if (g >= 0) begin
                if (we[g]) shadow[addr[g][9:2]] = wd[g];
                else       m_rd = shadow[addr[g][9:2]];
`ifdef ARB_ROUND_ROBIN_EN
                m_last = g;
`endif
            end
            if (m_owner < 0) begin
                if (g >= 0 && lk[g]) begin
                    m_owner = g;
                    m_held  = 0;
                end
            end else begin
                m_held++;
                if (m_held == LOCK_MAX) begin
                    m_err = 1;
`ifdef ARB_ROUND_ROBIN_EN
                    m_last = m_owner;
`endif
                    m_owner = -1;
                end else if (!req[m_owner] || !lk[m_owner]) begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        r0, w0, l0;
        logic [31:0] a0, d0;
        logic        r1, w1, l1;
        logic [31:0] a1, d1;
        logic        eg0, eg1, ev0, ev1;
        logic [31:0] erd;
        logic        eerr;
    } vec_t;

    function automatic vec_t mk(
        input logic rs,
        input logic r0, input logic w0, input logic l0, input logic [31:0] a0, input logic [31:0] d0,
        input logic r1, input logic w1, input logic l1, input logic [31:0] a1, input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic ev0, input logic ev1,
        input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
        v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    task automatic apply(input vec_t v, input bit use_tab);
        int          g;
        logic [31:0] e_addr, e_data;
        logic        e_we, e_rv0, e_rv1;
        @(negedge clk);
        rst = v.rst;
        req[0] = v.r0; we[0] = v.w0; lk[0] = v.l0; addr[0] = v.a0; wd[0] = v.d0;
        req[1] = v.r1; we[1] = v.w1; lk[1] = v.l1; addr[1] = v.a1; wd[1] = v.d1;
        #1;
        g      = model_grant();
        e_we   = (g >= 0) ? we[g]   : 1'b0;
        e_addr = (g >= 0) ? addr[g] : 32'd0;
        e_data = (g >= 0) ? wd[g]   : 32'd0;
        e_rv0  = m_rv[0] && !rst;
        e_rv1  = m_rv[1] && !rst;
        chk("gnt0",     m0_gnt,    (g == 0));
        chk("gnt1",     m1_gnt,    (g == 1));
        chk("mem_we",   mem_we,    e_we);
        chk("mem_addr", mem_addr,  e_addr);
        chk("mem_data", mem_wdata, e_data);
        chk("rvalid0",  m0_rvalid, e_rv0);
        chk("rvalid1",  m1_rvalid, e_rv1);
        chk("rdata0",   m0_rdata,  e_rv0 ? m_rd : 32'd0);
        chk("rdata1",   m1_rdata,  e_rv1 ? m_rd : 32'd0);
        chk("lock_err", lock_err,  m_err && !rst);
        if (use_tab) begin
            chk("tab_gnt0",     m0_gnt,    v.eg0);
            chk("tab_gnt1",     m1_gnt,    v.eg1);
            chk("tab_rvalid0",  m0_rvalid, v.ev0);
            chk("tab_rvalid1",  m1_rvalid, v.ev1);
            chk("tab_rdata0",   m0_rdata,  v.ev0 ? v.erd : 32'd0);
            chk("tab_rdata1",   m1_rdata,  v.ev1 ? v.erd : 32'd0);
            chk("tab_lock_err", lock_err,  v.eerr);
            chk("tab_mem_addr", mem_addr,  v.eg0 ? v.a0 : (v.eg1 ? v.a1 : 32'd0));
        end
        @(posedge clk);
        model_update(g);
        cyc++;
    endtask

    vec_t tab[$];

    initial begin
        vec_t        v;
        logic        pg0, pg1, g0, g1;
        logic [31:0] dbe;
        int          p_req, p_lock;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; we[i] = 0; lk[i] = 0; addr[i] = 0; wd[i] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'(i) + 32'h21;   // RAM[16] = 0x31
            shadow[i] = 32'(i) + 32'h21;
        end
        m_owner = -1; m_held = 0; m_rv[0] = 0; m_rv[1] = 0; m_err = 0; m_rd = 0;
`ifdef ARB_ROUND_ROBIN_EN
        m_last = 1;
`endif
        dbe = 32'hDEADBEEF;

        // reset state and gating under reset
        tab.push_back(mk(1, 0,0,0,0,0,         0,0,0,0,0,        0,0,0,0,0,0));
        tab.push_back(mk(1, 1,0,0,32'h40,0,    1,1,0,32'h44,5,   0,0,0,0,0,0));
        // single read of 0x40
        tab.push_back(mk(0, 1,0,0,32'h40,0,    0,0,0,0,0,        1,0,0,0,0,0));
        tab.push_back(mk(0, 0,0,0,0,0,         0,0,0,0,0,        0,0,1,0,32'h31,0));
        tab.push_back(mk(1, 0,0,0,0,0,         0,0,0,0,0,        0,0,0,0,0,0));
        // six cycles of contention
        pg0 = 0; pg1 = 0;
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            g0 = (i % 2 == 0);
`else
            g0 = 1'b1;
`endif
            g1 = ~g0;
            tab.push_back(mk(0, 1,0,0,32'h44,0, 1,0,0,32'h48,0,
                             g0, g1, pg0, pg1, pg0 ? 32'h32 : 32'h33, 0));
            pg0 = g0; pg1 = g1;
        end
        tab.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,pg0,pg1, pg0 ? 32'h32 : 32'h33, 0));
        // locked write then unlocking read by m1, m0 waits
        tab.push_back(mk(0, 0,0,0,0,0,         1,1,1,32'h10,dbe, 0,1,0,0,0,0));
        tab.push_back(mk(0, 1,0,0,32'h40,0,    1,0,0,32'h10,0,   0,1,0,0,0,0));
        tab.push_back(mk(0, 1,0,0,32'h40,0,    0,0,0,0,0,        1,0,0,1,dbe,0));
        tab.push_back(mk(0, 0,0,0,0,0,         0,0,0,0,0,        0,0,1,0,32'h31,0));
        // reset right after a granted read drops the read
        tab.push_back(mk(0, 1,0,0,32'h44,0,    0,0,0,0,0,        1,0,0,0,0,0));
        tab.push_back(mk(1, 1,0,0,32'h44,0,    1,0,0,32'h48,0,   0,0,0,0,0,0));
        tab.push_back(mk(0, 1,0,0,32'h48,0,    1,0,0,32'h4C,0,   1,0,0,0,0,0));
        tab.push_back(mk(0, 0,0,0,0,0,         0,0,0,0,0,        0,0,1,0,32'h33,0));
        // idle port
        for (int i = 0; i < 5; i++)
            tab.push_back(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));

        foreach (tab[i]) apply(tab[i], 1'b1);

        // watchdog: m1 holds req+lock on reads of 0x50, m0 waits on 0x54
        apply(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0), 1'b1);
        for (int k = 0; k <= 17; k++) begin
            v = mk(0, (k >= 1),0,0,32'h54,0, 1,0,1,32'h50,0,
                   (k == 17), (k <= 16), 0, (k >= 1), 32'h35, (k == 17));
            apply(v, 1'b1);
        end
        apply(mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,32'h36,0), 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            p_req  = (i < 400) ? 50 : 90;
            p_lock = (i < 400) ? 30 : 85;
            v.rst = ($urandom_range(0, 63) == 0);
            v.r0 = ($urandom_range(0, 99) < p_req);
            v.w0 = $urandom_range(0, 1) == 1;
            v.l0 = ($urandom_range(0, 99) < p_lock);
            v.a0 = {22'd0, 8'($urandom), 2'b00};
            v.d0 = $urandom;
            v.r1 = ($urandom_range(0, 99) < p_req);
            v.w1 = $urandom_range(0, 1) == 1;
            v.l1 = ($urandom_range(0, 99) < p_lock);
            v.a1 = {22'd0, 8'($urandom), 2'b00};
            v.d1 = $urandom;
            v.eg0 = 0; v.eg1 = 0; v.ev0 = 0; v.ev1 = 0; v.erd = 0; v.eerr = 0;
            apply(v, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
